// File: rtl/moving_average_pow2.sv
// Streaming moving-average filter with a run-time power-of-two window, signed data,
// warm-up tracking, restart on window change/clear and round-half-up division.
`timescale 1ns/1ps
module moving_average_pow2 #(
  parameter  int DATA_W       = 16,
  parameter  int MAX_LOG2_WIN = 6,
  localparam int LOG2_W       = $clog2(MAX_LOG2_WIN + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_data,
  input  logic [LOG2_W-1:0]        log2_window,
  input  logic                     clear,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_data,
  output logic                     out_full
);

  localparam int DEPTH = 1 << MAX_LOG2_WIN;
  localparam int PTR_W = MAX_LOG2_WIN;
  localparam int CNT_W = MAX_LOG2_WIN + 1;
  localparam int SUM_W = DATA_W + MAX_LOG2_WIN;

  logic signed [DATA_W-1:0] ring [DEPTH];

  logic [LOG2_W-1:0]       active_l, l_clamped, eff_l;
  logic                    restart;
  logic [CNT_W-1:0]        fill_cnt, eff_fill, win_size, next_fill;
  logic signed [SUM_W-1:0] sum, eff_sum, old_ext, in_ext, next_sum;
  logic [PTR_W-1:0]        wr_ptr, rd_ptr;

  logic                    s1_valid, s1_full;
  logic signed [SUM_W-1:0] s1_sum;
  logic [LOG2_W-1:0]       s1_l;
  logic signed [SUM_W-1:0] rnd, biased, shifted;

  logic                    s2_valid, s2_full;
  logic signed [DATA_W-1:0] s2_data;

  // A restart this cycle means the incoming sample already sees the new window and empty history
  always_comb begin
    l_clamped = (log2_window > LOG2_W'(MAX_LOG2_WIN)) ? LOG2_W'(MAX_LOG2_WIN) : log2_window;
    restart   = clear || (l_clamped != active_l);
    eff_l     = restart ? l_clamped : active_l;
    eff_fill  = restart ? '0 : fill_cnt;
    eff_sum   = restart ? '0 : sum;
    win_size  = CNT_W'(1) << eff_l;
    rd_ptr    = wr_ptr - PTR_W'(win_size);
    in_ext    = {{MAX_LOG2_WIN{in_data[DATA_W-1]}}, in_data};
    old_ext   = (eff_fill == win_size)
                ? {{MAX_LOG2_WIN{ring[rd_ptr][DATA_W-1]}}, ring[rd_ptr]} : '0;
    next_sum  = eff_sum + in_ext - old_ext;
    next_fill = (eff_fill == win_size) ? eff_fill : eff_fill + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset && in_valid) ring[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      active_l <= '0;
      sum      <= '0;
      fill_cnt <= '0;
      wr_ptr   <= '0;
      s1_valid <= 1'b0;
      s1_sum   <= '0;
      s1_l     <= '0;
      s1_full  <= 1'b0;
    end else begin
      active_l <= l_clamped;
      s1_valid <= in_valid;
      if (in_valid) begin
        sum      <= next_sum;
        fill_cnt <= next_fill;
        wr_ptr   <= wr_ptr + PTR_W'(1);
        s1_sum   <= next_sum;
        s1_l     <= eff_l;
        s1_full  <= (next_fill == win_size);
      end else if (restart) begin
        sum      <= '0;
        fill_cnt <= '0;
      end
    end
  end

  // Adding half the window before the arithmetic shift gives round-half-up for signed sums
  always_comb begin
    rnd     = (s1_l == '0) ? '0 : (SUM_W'(1) << (s1_l - LOG2_W'(1)));
    biased  = s1_sum + rnd;
    shifted = biased >>> s1_l;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_full   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_full  <= 1'b0;
    end else begin
      s2_valid  <= s1_valid;
      if (s1_valid) begin
        s2_data <= shifted[DATA_W-1:0];
        s2_full <= s1_full;
      end
      out_valid <= s2_valid;
      if (s2_valid) begin
        out_data <= s2_data;
        out_full <= s2_full;
      end
    end
  end

endmodule

// File: tb/tb_moving_average_pow2.sv
// Self-checking bench for moving_average_pow2: directed and random samples compared
// against a queue-based arithmetic model of the windowed average.
`timescale 1ns/1ps
module tb_moving_average_pow2;

  logic               clk;
  logic               reset;
  logic               in_valid;
  logic signed [15:0] in_data;
  logic [2:0]         log2_window;
  logic               clear;
  logic               out_valid;
  logic signed [15:0] out_data;
  logic               out_full;

  int checks   = 0;
  int failures = 0;

  int          m_l;
  int          hist[$];
  bit          p_valid [2];
  logic [15:0] p_data  [2];
  bit          p_full  [2];
  logic [15:0] last_data;
  bit          last_full;

  moving_average_pow2 dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .log2_window (log2_window),
    .clear       (clear),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_full    (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint round_avg(input longint s, input int l);
    longint w, n, q;
    w = longint'(1) << l;
    n = s + (w / 2);
    q = n / w;
    if ((n % w) != 0 && n < 0) q = q - 1;
    return q;
  endfunction

  task automatic model_reset();
    m_l = 0;
    hist.delete();
    for (int i = 0; i < 2; i++) begin
      p_valid[i] = 1'b0;
      p_data[i]  = '0;
      p_full[i]  = 1'b0;
    end
    last_data = '0;
    last_full = 1'b0;
  endtask

  task automatic check_zero_outputs();
    checks++;
    assert (out_valid === 1'b0) else begin
      failures++; $error("[TB] FAIL reset_out_valid obs=%0b exp=0", out_valid);
    end
    checks++;
    assert (out_data === 16'sd0) else begin
      failures++; $error("[TB] FAIL reset_out_data obs=%0d exp=0", out_data);
    end
    checks++;
    assert (out_full === 1'b0) else begin
      failures++; $error("[TB] FAIL reset_out_full obs=%0b exp=0", out_full);
    end
  endtask

  task automatic check_output();
    logic [15:0] exp_d;
    bit          exp_f;
    exp_d = p_valid[1] ? p_data[1] : last_data;
    exp_f = p_valid[1] ? p_full[1] : last_full;
    checks++;
    assert (out_valid === p_valid[1]) else begin
      failures++; $error("[TB] FAIL out_valid obs=%0b exp=%0b", out_valid, p_valid[1]);
    end
    checks++;
    assert (out_data === exp_d) else begin
      failures++; $error("[TB] FAIL out_data obs=%0d exp=%0d", out_data, $signed(exp_d));
    end
    checks++;
    assert (out_full === exp_f) else begin
      failures++; $error("[TB] FAIL out_full obs=%0b exp=%0b", out_full, exp_f);
    end
    last_data = exp_d;
    last_full = exp_f;
  endtask

  task automatic apply_stimulus(input bit v, input int d, input int lw, input bit clr);
    int     lc, n, w;
    longint s;
    bit     nv, nf;
    logic [15:0] nd;
    @(negedge clk);
    in_valid    = v;
    in_data     = 16'(d);
    log2_window = 3'(lw);
    clear       = clr;
    @(posedge clk);
    #1;
    lc = (lw > 6) ? 6 : lw;
    if (clr || lc != m_l) begin
      m_l = lc;
      hist.delete();
    end
    nv = v; nd = '0; nf = 1'b0;
    if (v) begin
      hist.push_back(d);
      if (hist.size() > 64) void'(hist.pop_front());
      n = hist.size();
      w = 1 << m_l;
      s = 0;
      for (int i = (n > w ? n - w : 0); i < n; i++) s += hist[i];
      nf = (n >= w);
      nd = 16'(round_avg(s, m_l));
    end
    check_output();
    p_valid[1] = p_valid[0]; p_data[1] = p_data[0]; p_full[1] = p_full[0];
    p_valid[0] = nv;         p_data[0] = nd;         p_full[0] = nf;
  endtask

  task automatic idle(input int n, input int lw);
    for (int i = 0; i < n; i++) apply_stimulus(1'b0, 0, lw, 1'b0);
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_data = '0; log2_window = '0; clear = 1'b0;
    model_reset();
    #1;
    check_zero_outputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;

    $display("[TB] window 4 warm-up ramp");
    for (int i = 1; i <= 5; i++) apply_stimulus(1'b1, 4 * i, 2, 1'b0);
    idle(3, 2);

    $display("[TB] window 2 negative rounding");
    apply_stimulus(1'b1, -3, 1, 1'b0);
    apply_stimulus(1'b1, -4, 1, 1'b0);
    idle(3, 1);

    $display("[TB] window 64 full-scale extremes");
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, 32767, 6, 1'b0);
    for (int i = 0; i < 64; i++) apply_stimulus(1'b1, -32768, 6, 1'b0);
    idle(3, 6);

    $display("[TB] window change mid-stream and clamped select");
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, 10, 2, 1'b0);
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 10, 3, 1'b0);
    for (int i = 0; i < 70; i++) apply_stimulus(1'b1, $urandom_range(0, 65535) - 32768, 7, 1'b0);
    idle(3, 6);

    $display("[TB] valid gaps and clear with valid");
    apply_stimulus(1'b1, 5, 2, 1'b0);
    apply_stimulus(1'b0, 0, 2, 1'b0);
    apply_stimulus(1'b0, 0, 2, 1'b0);
    apply_stimulus(1'b1, 9, 2, 1'b0);
    apply_stimulus(1'b1, 13, 2, 1'b1);
    apply_stimulus(1'b1, 7, 2, 1'b0);
    apply_stimulus(1'b0, 0, 2, 1'b1);
    apply_stimulus(1'b1, -21, 2, 1'b0);
    idle(3, 2);

    $display("[TB] randomized traffic");
    begin
      int lw;
      lw = 3;
      for (int i = 0; i < 300; i++) begin
        if ($urandom_range(0, 19) == 0) lw = $urandom_range(0, 7);
        apply_stimulus($urandom_range(0, 3) != 0, $urandom_range(0, 65535) - 32768,
                       lw, $urandom_range(0, 39) == 0);
      end
    end

    $display("[TB] reset mid-stream");
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 100 * (i + 1), 1, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check_zero_outputs();
    model_reset();
    in_valid = 1'b0; in_data = '0; log2_window = '0; clear = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(3, 0);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b1, $urandom_range(0, 65535) - 32768, 0, 1'b0);
    idle(3, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
